// File: rtl/seq_checker.sv
// Lock/error checker for a 3-bit T-flip-flop sequence (000,001,011,101,111).
// Define SEQ_CHK_ERRCNT_EN to build the saturating error counter; otherwise err_count is tied to 0.
module seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       q,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       expected
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

  state_t     state;
  logic [2:0] match_cnt;
  logic [2:0] cnt_inc;
  logic [2:0] q_next;
  logic       code_legal;
  logic       err_event;

  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'b000:  return 3'b001;
      3'b001:  return 3'b011;
      3'b011:  return 3'b101;
      3'b101:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // An error is an illegal code while hunting, or any miss of the prediction once synced.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    code_legal = (q != 3'b010) && (q != 3'b100) && (q != 3'b110);
    q_next     = next_code(q);
    cnt_inc    = match_cnt + 3'd1;
    err_event  = 1'b0;
    if (valid) begin
      err_event = (state == HUNT) ? !code_legal : (q != expected);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= HUNT;
      match_cnt <= '0;
      expected  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= err_event;
      if (valid) begin
        unique case (state)
          HUNT: begin
            if (code_legal) begin
              state     <= CHECK;
              match_cnt <= '0;
              expected  <= q_next;
            end
          end
          CHECK, LOCKED: begin
            if (err_event) begin
              locked <= 1'b0;
              if (code_legal) begin
                state     <= CHECK;
                match_cnt <= '0;
                expected  <= q_next;
              end else begin
                state <= HUNT;
              end
            end else begin
              expected <= q_next;
              if (state == CHECK) begin
                match_cnt <= cnt_inc;
                if (cnt_inc == LOCK_TGT) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_CHK_ERRCNT_EN
  // Counts in step with the err pulse and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= '0;
    end else if (err_event && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: a default instance (LOCK_CNT=3, ERR_W=8) and a
// LOCK_CNT=1, ERR_W=2 instance share stimulus; a reference model fills the expectation queue.
module tb_seq_checker;

`ifdef SEQ_CHK_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // Successor table indexed by code; -1 marks an illegal code.
  localparam int SUCC [8] = '{1, 3, -1, 5, -1, 7, -1, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] q = 3'b000;

  logic       locked_a, err_a;
  logic [7:0] ec_a;
  logic [2:0] exp_a;
  logic       locked_b, err_b;
  logic [1:0] ec_b;
  logic [2:0] exp_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_checker #(.LOCK_CNT(3), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset), .valid(valid), .q(q),
    .locked(locked_a), .err(err_a), .err_count(ec_a), .expected(exp_a)
  );

  seq_checker #(.LOCK_CNT(1), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .valid(valid), .q(q),
    .locked(locked_b), .err(err_b), .err_count(ec_b), .expected(exp_b)
  );

  typedef struct {
    int         st;   // 0 hunt, 1 check, 2 locked
    int         cnt;
    logic [2:0] exp;
    logic       locked;
    logic       err;
    int         ec;
  } mdl_t;

  typedef struct {
    logic       a_locked, a_err;
    logic [7:0] a_ec;
    logic [2:0] a_exp;
    logic       b_locked, b_err;
    logic [1:0] b_ec;
    logic [2:0] b_exp;
  } exp_t;

  mdl_t ma, mb;
  exp_t sb[$];
  exp_t got;

  function automatic mdl_t mdl_step(input mdl_t m, input int lc, input int ecmax,
                                    input logic rst, input logic v, input logic [2:0] c);
    mdl_t n = m;
    bit   lg = (SUCC[c] >= 0);
    n.err = 1'b0;
    if (!rst) begin
      n.st = 0; n.cnt = 0; n.exp = 3'b000; n.locked = 1'b0; n.ec = 0;
      return n;
    end
    if (!v) return n;
    if (m.st == 0) begin
      if (lg) begin n.st = 1; n.cnt = 0; n.exp = 3'(SUCC[c]); end
      else n.err = 1'b1;
    end else if (c == m.exp) begin
      n.exp = 3'(SUCC[c]);
      if (m.st == 1) begin
        n.cnt = m.cnt + 1;
        if (n.cnt == lc) n.st = 2;
      end
    end else begin
      n.err = 1'b1;
      if (lg) begin n.st = 1; n.cnt = 0; n.exp = 3'(SUCC[c]); end
      else n.st = 0;
    end
    n.locked = (n.st == 2);
    if (CNT_ON && n.err && n.ec < ecmax) n.ec = n.ec + 1;
    return n;
  endfunction

  // Drive one cycle at the falling edge, queue the model's prediction, return just after the rising edge.
  task automatic cycle(input logic rst, input logic v, input logic [2:0] c);
    exp_t e;
    @(negedge clk);
    reset = rst;
    valid = v;
    q     = c;
    ma = mdl_step(ma, 3, 255, rst, v, c);
    mb = mdl_step(mb, 1, 3, rst, v, c);
    e.a_locked = ma.locked; e.a_err = ma.err; e.a_ec = 8'(ma.ec); e.a_exp = ma.exp;
    e.b_locked = mb.locked; e.b_err = mb.err; e.b_ec = 2'(mb.ec); e.b_exp = mb.exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      got = sb.pop_front();
      checks++;
      if ({locked_a, err_a, exp_a, ec_a} !== {got.a_locked, got.a_err, got.a_exp, got.a_ec}) begin
        errors++;
        $display("FAIL sb_a t=%0t: locked/err/expected/err_count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 $time, locked_a, err_a, exp_a, ec_a, got.a_locked, got.a_err, got.a_exp, got.a_ec);
      end
      checks++;
      if ({locked_b, err_b, exp_b, ec_b} !== {got.b_locked, got.b_err, got.b_exp, got.b_ec}) begin
        errors++;
        $display("FAIL sb_b t=%0t: locked/err/expected/err_count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 $time, locked_b, err_b, exp_b, ec_b, got.b_locked, got.b_err, got.b_exp, got.b_ec);
      end
    end
  end

  task automatic test_reset();
    cycle(1'b0, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b011);
    checks++;
    if ({locked_a, err_a, exp_a, ec_a} !== {1'b0, 1'b0, 3'b000, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: got %b/%b/%b/%0d want 0/0/000/0", locked_a, err_a, exp_a, ec_a);
    end
  endtask

  task automatic test_clean_lock();
    logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b000, 3'b001, 3'b011};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, seq[i]);
      checks++;
      if (err_a !== 1'b0 || err_b !== 1'b0) begin
        errors++;
        $display("FAIL clean_lock_err sample %0d: err_a=%b err_b=%b want 0", i, err_a, err_b);
      end
      checks++;
      if (locked_a !== (i >= 3)) begin
        errors++;
        $display("FAIL clean_lock_a sample %0d: locked=%b want %b", i, locked_a, (i >= 3));
      end
      if (i == 1) begin
        checks++;
        if (locked_b !== 1'b1) begin
          errors++;
          $display("FAIL lock_cnt1 sample %0d: locked_b=%b want 1", i, locked_b);
        end
      end
    end
  endtask

  task automatic test_locked_mismatch();
    checks++;
    if (exp_a !== 3'b101) begin
      errors++;
      $display("FAIL mismatch_pre: expected=%b want 101", exp_a);
    end
    cycle(1'b1, 1'b1, 3'b000);
    checks++;
    if ({err_a, locked_a, exp_a, ec_a} !== {1'b1, 1'b0, 3'b001, (CNT_ON ? 8'd1 : 8'd0)}) begin
      errors++;
      $display("FAIL locked_mismatch: err/locked/expected/err_count got %b/%b/%b/%0d want 1/0/001/%0d",
               err_a, locked_a, exp_a, ec_a, CNT_ON ? 1 : 0);
    end
    cycle(1'b1, 1'b1, 3'b001);
    checks++;
    if (err_a !== 1'b0 || locked_a !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_one_pulse: err=%b locked=%b want 0/0", err_a, locked_a);
    end
  endtask

  task automatic test_illegal();
    cycle(1'b1, 1'b1, 3'b110);
    checks++;
    if (err_a !== 1'b1 || locked_a !== 1'b0 || locked_b !== 1'b0) begin
      errors++;
      $display("FAIL illegal_code: err=%b locked_a=%b locked_b=%b want 1/0/0", err_a, locked_a, locked_b);
    end
    cycle(1'b1, 1'b1, 3'b011);
    checks++;
    if (err_a !== 1'b0 || exp_a !== 3'b101) begin
      errors++;
      $display("FAIL illegal_resync: err=%b expected=%b want 0/101", err_a, exp_a);
    end
  endtask

  task automatic test_valid_gaps();
    logic [2:0] e_hold;
    logic [7:0] c_hold;
    cycle(1'b1, 1'b1, 3'b101);
    cycle(1'b1, 1'b1, 3'b111);
    cycle(1'b1, 1'b1, 3'b000);
    checks++;
    if (locked_a !== 1'b1) begin
      errors++;
      $display("FAIL gaps_relock: locked=%b want 1", locked_a);
    end
    e_hold = ma.exp;
    c_hold = 8'(ma.ec);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 3'($urandom_range(0, 7)));
      checks++;
      if ({locked_a, err_a, exp_a, ec_a} !== {1'b1, 1'b0, e_hold, c_hold}) begin
        errors++;
        $display("FAIL valid_gap %0d: locked/err/expected/err_count got %b/%b/%b/%0d want 1/0/%b/%0d",
                 i, locked_a, err_a, exp_a, ec_a, e_hold, c_hold);
      end
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (ec_a !== (CNT_ON ? 8'd2 : 8'd0) || locked_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: err_count=%0d locked=%b want %0d/1", ec_a, locked_a, CNT_ON ? 2 : 0);
    end
    cycle(1'b0, 1'b1, 3'b110);
    checks++;
    if ({locked_a, err_a, exp_a, ec_a} !== {1'b0, 1'b0, 3'b000, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid: locked/err/expected/err_count got %b/%b/%b/%0d want 0/0/000/0",
               locked_a, err_a, exp_a, ec_a);
    end
  endtask

  task automatic test_saturation();
    logic [2:0] bad [3] = '{3'b010, 3'b100, 3'b110};
    logic [1:0] want;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, bad[i % 3]);
      want = CNT_ON ? ((i >= 2) ? 2'd3 : 2'(i + 1)) : 2'd0;
      checks++;
      if (ec_b !== want || err_b !== 1'b1) begin
        errors++;
        $display("FAIL saturate %0d: err_count=%0d err=%b want %0d/1", i, ec_b, err_b, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] c;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0 && ma.st != 0) c = ma.exp;
      else c = 3'($urandom_range(0, 7));
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0), c);
    end
  endtask

  initial begin
    ma = '{st: 0, cnt: 0, exp: 3'b000, locked: 1'b0, err: 1'b0, ec: 0};
    mb = ma;
    test_reset();
    test_clean_lock();
    test_locked_mismatch();
    test_illegal();
    test_valid_gaps();
    test_reset_mid();
    test_saturation();
    cycle(1'b0, 1'b0, 3'b000);
    test_back_to_back();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
